// File: rtl/next_pc_pkg.sv
// Shared types and constants for the next-PC unit: instruction kinds,
// controller states and the instruction alignment mask.
package next_pc_pkg;

  // Control-flow class of the retiring instruction, encoded as on the kind port.
  typedef enum logic [1:0] {
    SEQ    = 2'b00,
    BRANCH = 2'b01,
    JAL    = 2'b10,
    JALR   = 2'b11
  } kind_t;

  // Controller states: idle, waiting on the branch comparator, committing.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_BR = 2'b01,
    COMMIT  = 2'b10
  } npc_state_t;

  // Low PC bits that must be zero for a legal (word-aligned) fetch target.
  localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

endpackage : next_pc_pkg

// File: rtl/next_pc_unit.sv
// Architectural program counter and next-PC computation for retiring
// instructions (sequential, conditional branch, JAL, JALR). Branch outcomes
// come from an external comparator launched with a one-cycle br_start pulse.
module next_pc_unit
  import next_pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  kind,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic        br_start,
  input  logic        br_done,
  input  logic        br_jump,
  output logic        done,
  output logic [31:0] pc,
  output logic [31:0] link,
  output logic        misaligned
);

  // Architectural and control state (current / next).
  npc_state_t  state_q,      state_d;
  logic [31:0] pc_q,         pc_d;
  logic [31:0] link_q,       link_d;
  logic        done_q,       done_d;
  logic        mis_q,        mis_d;
  logic        br_start_q,   br_start_d;

  // Operands captured with start, plus the comparator outcome.
  kind_t       kind_q,       kind_d;
  logic [31:0] imm_q,        imm_d;
  logic [31:0] rs1_q,        rs1_d;
  logic        taken_q,      taken_d;

  // Datapath: one shared adder for pc+imm / rs1+imm and a separate incrementer.
  logic [31:0] add_base;
  logic [31:0] add_sum;
  logic [31:0] pc_inc;
  logic [31:0] target;

  // Target datapath, evaluated from the latched operands and current PC.
  always_comb begin
    add_base = (kind_q == JALR) ? rs1_q : pc_q;
    add_sum  = add_base + imm_q;
    pc_inc   = pc_q + 32'd4;
    unique case (kind_q)
      SEQ:     target = pc_inc;
      BRANCH:  target = taken_q ? add_sum : pc_inc;
      JAL:     target = add_sum;
      JALR:    target = {add_sum[31:1], 1'b0};
      default: target = pc_inc;
    endcase
  end

  // Next-state and next-output logic for the IDLE / WAIT_BR / COMMIT controller.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    link_d     = link_q;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    br_start_d = 1'b0;
    kind_d     = kind_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    taken_d    = taken_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          kind_d  = kind_t'(kind);
          imm_d   = imm;
          rs1_d   = rs1;
          taken_d = 1'b0;
          if (kind_t'(kind) == BRANCH) begin
            br_start_d = 1'b1;
            state_d    = WAIT_BR;
          end else begin
            state_d    = COMMIT;
          end
        end
      end

      WAIT_BR: begin
        // br_start falls back to its default of 0 here: a single-cycle pulse.
        if (br_done) begin
          taken_d = br_jump;
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        done_d = 1'b1;
        link_d = pc_inc;
        if ((target[1:0] & INSTR_ALIGN_MASK) != 2'b00) begin
          mis_d = 1'b1;
        end else begin
          pc_d  = target;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation and drops pending results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      link_q     <= '0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      br_start_q <= 1'b0;
      kind_q     <= SEQ;
      imm_q      <= '0;
      rs1_q      <= '0;
      taken_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      pc_q       <= pc_d;
      link_q     <= link_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
      br_start_q <= br_start_d;
      kind_q     <= kind_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      taken_q    <= taken_d;
    end
  end

  assign pc         = pc_q;
  assign link       = link_q;
  assign done       = done_q;
  assign misaligned = mis_q;
  assign br_start   = br_start_q;

endmodule : next_pc_unit

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios plus randomized
// instruction streams checked against a PC model built from the target rules.
module tb_next_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  kind;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        br_start;
  logic        br_done;
  logic        br_jump;
  logic        done;
  logic [31:0] pc;
  logic [31:0] link;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;

  // Reference model state: the architectural PC as the bench expects it.
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  next_pc_unit #(.RESET_VECTOR(RV)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .kind       (kind),
    .imm        (imm),
    .rs1        (rs1),
    .br_start   (br_start),
    .br_done    (br_done),
    .br_jump    (br_jump),
    .done       (done),
    .pc         (pc),
    .link       (link),
    .misaligned (misaligned)
  );

  // Issues one instruction starting at a negedge (so it can follow the previous
  // done back-to-back), plays the comparator, and checks latency and results.
  // Ends at the negedge on which done is observed high.
  task automatic do_instr(input string tag, input logic [1:0] k, input logic [31:0] im,
                          input logic [31:0] r1, input logic jmp, input bit poke_start);
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_mis;
    int          exp_lat;
    int          cyc;
    int          bs_cnt;
    bit          got;
    case (k)
      2'd0:    tgt = m_pc + 32'd4;
      2'd1:    tgt = jmp ? m_pc + im : m_pc + 32'd4;
      2'd2:    tgt = m_pc + im;
      default: tgt = (r1 + im) & 32'hFFFF_FFFE;
    endcase
    exp_mis = (tgt % 4) != 0;
    exp_pc  = exp_mis ? m_pc : tgt;
    exp_lat = (k == 2'd1) ? 4 : 1;

    start = 1'b1; kind = k; imm = im; rs1 = r1;
    @(posedge clk); #1;
    // Scramble the operand inputs: the DUT must use what it latched.
    start = 1'b0; kind = 2'($urandom); imm = $urandom; rs1 = $urandom;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_clear: done=%b required 0", tag, done);
    end
    bs_cnt = (br_start === 1'b1) ? 1 : 0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk); cyc++; #1;
      br_done = (k == 2'd1) && (cyc == 2);
      br_jump = (cyc == 2) ? jmp : 1'($urandom);
      if (poke_start) begin
        start = (cyc == 1) || (cyc == 2);
        kind  = 2'($urandom);
        imm   = $urandom;
        rs1   = $urandom;
      end
      @(negedge clk);
      if (br_start === 1'b1) bs_cnt++;
      if (done === 1'b1) got = 1'b1;
    end
    start   = 1'b0;
    br_done = 1'b0;

    checks++;
    if (!got || cyc != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got=%0b edges=%0d required %0d", tag, got, cyc, exp_lat);
    end
    checks++;
    if (bs_cnt != ((k == 2'd1) ? 1 : 0)) begin
      failures++;
      $display("FAIL %s br_start_cycles: %0d required %0d", tag, bs_cnt, (k == 2'd1) ? 1 : 0);
    end
    checks++;
    if (pc !== exp_pc) begin
      failures++;
      $display("FAIL %s pc: %h required %h", tag, pc, exp_pc);
    end
    checks++;
    if (link !== m_pc + 32'd4) begin
      failures++;
      $display("FAIL %s link: %h required %h", tag, link, m_pc + 32'd4);
    end
    checks++;
    if (misaligned !== exp_mis) begin
      failures++;
      $display("FAIL %s misaligned: %b required %b", tag, misaligned, exp_mis);
    end
    m_pc = exp_pc;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; kind = 2'd0; imm = '0; rs1 = '0;
    br_done = 1'b0; br_jump = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pc, link, done, misaligned, br_start} !== {RV, 32'h0, 3'b000}) begin
      failures++;
      $display("FAIL reset_values: pc=%h link=%h done=%b mis=%b br_start=%b required pc=%h rest 0",
               pc, link, done, misaligned, br_start, RV);
    end
    m_pc = RV;
  endtask

  task automatic test_seq();
    do_instr("seq_first", 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h104 || link !== 32'h104) begin
      failures++;
      $display("FAIL seq_plan: pc=%h link=%h required 104/104", pc, link);
    end
  endtask

  task automatic test_branch();
    do_instr("set_pc_100a", 2'd3, 32'h0, 32'h100, 1'b0, 1'b0);
    do_instr("br_taken", 2'd1, 32'h10, 32'h0, 1'b1, 1'b0);
    checks++;
    if (pc !== 32'h110 || link !== 32'h104) begin
      failures++;
      $display("FAIL br_taken_plan: pc=%h link=%h required 110/104", pc, link);
    end
    do_instr("set_pc_100b", 2'd3, 32'h0, 32'h100, 1'b0, 1'b0);
    do_instr("br_not_taken", 2'd1, 32'h10, 32'h0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h104) begin
      failures++;
      $display("FAIL br_not_taken_plan: pc=%h required 104", pc);
    end
  endtask

  task automatic test_jalr();
    do_instr("jalr_clear_bit0", 2'd3, 32'hFFFF_FFFF, 32'h205, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h204) begin
      failures++;
      $display("FAIL jalr_plan: pc=%h required 204", pc);
    end
    do_instr("jalr_misaligned", 2'd3, 32'h0, 32'h203, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h204 || misaligned !== 1'b1) begin
      failures++;
      $display("FAIL jalr_fault_plan: pc=%h mis=%b required 204/1", pc, misaligned);
    end
  endtask

  task automatic test_wrap();
    do_instr("set_pc_top", 2'd3, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    do_instr("seq_wrap", 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h0) begin
      failures++;
      $display("FAIL seq_wrap_plan: pc=%h required 00000000", pc);
    end
    do_instr("seq_to_4", 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    do_instr("jal_wrap", 2'd2, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL jal_wrap_plan: pc=%h required fffffffc", pc);
    end
  endtask

  task automatic test_start_ignored();
    int extra;
    do_instr("br_with_pokes", 2'd1, 32'h20, 32'h0, 1'b1, 1'b1);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL start_ignored_extra_done: %0d pulses required 0", extra);
    end
  endtask

  task automatic test_reset_mid_branch();
    int dones;
    start = 1'b1; kind = 2'd1; imm = 32'h40;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (pc !== RV || done !== 1'b0 || br_start !== 1'b0 || link !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_branch: pc=%h done=%b br_start=%b link=%h required %h/0/0/0",
               pc, done, br_start, link, RV);
    end
    @(negedge clk);
    rst = 1'b1;
    m_pc = RV;
    @(posedge clk); #1;
    br_done = 1'b1; br_jump = 1'b1;
    @(posedge clk); #1;
    br_done = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || pc !== RV) begin
      failures++;
      $display("FAIL stale_br_done: dones=%0d pc=%h required 0/%h", dones, pc, RV);
    end
  endtask

  task automatic test_random();
    logic [1:0]  k;
    logic [31:0] im;
    logic [31:0] r1;
    for (int i = 0; i < 60; i++) begin
      k  = 2'($urandom);
      im = $urandom;
      r1 = $urandom;
      if ($urandom_range(3, 0) != 0) im[1:0] = 2'b00;
      if ($urandom_range(3, 0) == 0) im = im >>> 20;
      do_instr("random", k, im, r1, 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_jalr();
    test_wrap();
    test_start_ignored();
    test_reset_mid_branch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_next_pc_unit
